// File: rtl/apb_timer_mch.sv
// apb_timer_mch: NUM_CH up/down timers behind one zero-wait-state APB slave, sharing a 4-bit prescaler.
// Auto-reload (TCR.ARL) is built only when TIMER_AUTORELOAD_EN is defined; otherwise wraps go to 0 / max.
module apb_timer_mch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [NUM_CH-1:0]     IRQ
);
`ifdef TIMER_AUTORELOAD_EN
    localparam logic [7:0] TCR_MASK = 8'hFB;
`else
    localparam logic [7:0] TCR_MASK = 8'hBB;
`endif
    localparam int NUM_REGS = 4 * NUM_CH;

    logic [3:0]  div_q, div_d;
    logic [3:0]  tick;
    logic [31:0] paddr_ext;
    logic [31:0] ch_idx;
    logic [1:0]  reg_idx;
    logic        addr_ok;
    logic        wr_access;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [DATA_WIDTH-1:0] tdr_all  [NUM_CH];
    logic [7:0]            tcr_all  [NUM_CH];
    logic [1:0]            tsr_all  [NUM_CH];
    logic [DATA_WIDTH-1:0] tcnt_all [NUM_CH];

    assign paddr_ext = 32'(PADDR);
    assign ch_idx    = paddr_ext >> 2;
    assign reg_idx   = PADDR[1:0];
    assign addr_ok   = (paddr_ext < 32'(NUM_REGS));
    // TCNT is read-only, so a write to it never reaches the channel logic
    assign wr_access = PSEL && PENABLE && PWRITE && addr_ok && (reg_idx != 2'd3);

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL && PENABLE && (!addr_ok || (PWRITE && reg_idx == 2'd3));

    assign div_d   = div_q + 4'd1;
    assign tick[0] = div_q[0];
    assign tick[1] = &div_q[1:0];
    assign tick[2] = &div_q[2:0];
    assign tick[3] = &div_q[3:0];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 32'(c)) begin
                case (reg_idx)
                    2'd0:    rd_data = tdr_all[c];
                    2'd1:    rd_data = DATA_WIDTH'(tcr_all[c]);
                    2'd2:    rd_data = DATA_WIDTH'(tsr_all[c]);
                    default: rd_data = tcnt_all[c];
                endcase
            end
        end
        PRDATA = (PSEL && !PWRITE && addr_ok) ? rd_data : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
            logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
            logic [7:0]            tcr_q, tcr_d;
            logic [1:0]            tsr_q, tsr_d;
            logic                  irq_q;
            logic                  sel, ch_tick, arl, ovf_set, udf_set;

            assign sel     = wr_access && (ch_idx == 32'(gi));
            assign ch_tick = tick[tcr_q[1:0]];
`ifdef TIMER_AUTORELOAD_EN
            assign arl = tcr_q[6];
`else
            assign arl = 1'b0;
`endif

            always_comb begin
                tdr_d   = tdr_q;
                tcr_d   = tcr_q;
                tcnt_d  = tcnt_q;
                ovf_set = 1'b0;
                udf_set = 1'b0;
                if (sel && reg_idx == 2'd0) tdr_d = PWDATA;
                if (sel && reg_idx == 2'd1) tcr_d = PWDATA[7:0] & TCR_MASK;
                if (tcr_q[7]) begin
                    tcnt_d = tdr_q;
                end else if (tcr_q[4] && ch_tick) begin
                    if (tcr_q[5]) begin
                        if (tcnt_q == '0) begin
                            udf_set = 1'b1;
                            tcnt_d  = arl ? tdr_q : '1;
                        end else begin
                            tcnt_d = tcnt_q - DATA_WIDTH'(1);
                        end
                    end else begin
                        if (&tcnt_q) begin
                            ovf_set = 1'b1;
                            tcnt_d  = arl ? tdr_q : '0;
                        end else begin
                            tcnt_d = tcnt_q + DATA_WIDTH'(1);
                        end
                    end
                end
                // a hardware set in the same cycle as a W1C keeps the flag
                tsr_d = tsr_q;
                if (sel && reg_idx == 2'd2) tsr_d = tsr_q & ~PWDATA[1:0];
                tsr_d = tsr_d | {udf_set, ovf_set};
            end

            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    tdr_q  <= '0;
                    tcr_q  <= '0;
                    tsr_q  <= '0;
                    tcnt_q <= '0;
                    irq_q  <= 1'b0;
                end else begin
                    tdr_q  <= tdr_d;
                    tcr_q  <= tcr_d;
                    tsr_q  <= tsr_d;
                    tcnt_q <= tcnt_d;
                    irq_q  <= tcr_q[3] & (|tsr_q);
                end
            end

            assign tdr_all[gi]  = tdr_q;
            assign tcr_all[gi]  = tcr_q;
            assign tsr_all[gi]  = tsr_q;
            assign tcnt_all[gi] = tcnt_q;
            assign IRQ[gi]      = irq_q;
        end
    endgenerate
endmodule

// File: tb/tb_apb_timer_mch.sv
// Directed bench for apb_timer_mch: a register access vector table plus cycle-exact sequences
// for wrap, W1C-vs-set, load, auto-reload, prescaler rates and mid-count reset.
module tb_apb_timer_mch;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NCH = 4;
`ifdef TIMER_AUTORELOAD_EN
    localparam logic [7:0] TCR_FF_EXP = 8'hFB;
    localparam logic [7:0] ARL_WRAP   = 8'hF0;
    localparam logic [7:0] TCR2_EXP   = 8'h60;
`else
    localparam logic [7:0] TCR_FF_EXP = 8'hBB;
    localparam logic [7:0] ARL_WRAP   = 8'hFF;
    localparam logic [7:0] TCR2_EXP   = 8'h20;
`endif

    logic           PCLK = 1'b0;
    logic           PRESET, PSEL, PENABLE, PWRITE;
    logic [AW-1:0]  PADDR;
    logic [DW-1:0]  PWDATA, PRDATA;
    logic           PREADY, PSLVERR;
    logic [NCH-1:0] IRQ;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        bit         exp_err;
    } vec_t;
    vec_t vecs[$];

    apb_timer_mch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Called at a negedge; commits on the second posedge and returns at the following negedge.
    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 begin data = PRDATA; err = PSLVERR; end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        logic e;
        apb_write(addr, data, e);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic       e;
        apb_read(addr, d, e);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        do_reset();

        check("reset irq", IRQ, 4'b0000);
        check("reset pready", PREADY, 1'b1);
        check("reset pslverr", PSLVERR, 1'b0);
        check("idle prdata", PRDATA, 8'h00);

        // register map after reset and basic access rules
        for (int a = 0; a < 4 * NCH; a++) vecs.push_back('{1'b0, 8'(a), 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd16,  8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'd255, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 8'd3,   8'h55, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'd3,   8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'd16,  8'h12, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 8'd4,   8'hA5, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd4,   8'h00, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 8'd5,   8'hFF, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd5,   8'h00, TCR_FF_EXP, 1'b0});
        vecs.push_back('{1'b0, 8'd7,   8'h00, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 8'd5,   8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd6,   8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'd6,   8'hFF, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd6,   8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'd7,   8'h00, 8'hA5, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
                check($sformatf("v%0d wr @%0d pslverr", i, vecs[i].addr), e, vecs[i].exp_err);
            end else begin
                apb_read(vecs[i].addr, d, e);
                check($sformatf("v%0d rd @%0d data", i, vecs[i].addr), d, vecs[i].exp_data);
                check($sformatf("v%0d rd @%0d pslverr", i, vecs[i].addr), e, vecs[i].exp_err);
            end
        end

        // Cycle-exact: after reset release the divider is odd before every even edge P2, P4, ...
        do_reset();
        wr(8'd0, 8'hFF);          // P2
        wr(8'd1, 8'h80);          // P4 LOAD on
        wr(8'd1, 8'h00);          // P6 LOAD off
        wr(8'd1, 8'h10);          // P8 EN up CKS=00, wrap on P10
        wr(8'd2, 8'h01);          // P10 W1C on the wrap edge
        wr(8'd1, 8'h00);          // P12 disable, one more tick at P12
        rd_chk("w1c vs set tsr0", 8'd2, 8'h01);
        rd_chk("wrap then +1 tcnt0", 8'd3, 8'h01);
        check("irq ie=0", IRQ, 4'b0000);
        wr(8'd1, 8'h08);
        @(negedge PCLK);
        check("irq ie=1", IRQ, 4'b0001);
        wr(8'd2, 8'h01);
        @(negedge PCLK);
        check("irq after w1c", IRQ, 4'b0000);
        rd_chk("tsr0 cleared", 8'd2, 8'h00);

        // Ch1: loads across the wrap boundary never raise flags
        wr(8'd5, 8'h20);
        wr(8'd4, 8'h00);
        wr(8'd5, 8'hA0);
        wr(8'd5, 8'h20);
        wr(8'd4, 8'hFF);
        wr(8'd5, 8'hA0);
        wr(8'd5, 8'h20);
        rd_chk("ch1 load 0xff", 8'd7, 8'hFF);
        rd_chk("ch1 no udf", 8'd6, 8'h00);
        wr(8'd5, 8'h80);
        wr(8'd4, 8'h00);          // LOAD still held: reloads the new TDR
        wr(8'd5, 8'h00);
        rd_chk("ch1 held load", 8'd7, 8'h00);
        rd_chk("ch1 no ovf", 8'd6, 8'h00);

        // Ch2: down from 0 for a 2-edge enable window (exactly one CKS=00 tick)
        wr(8'd8, 8'hF0);
        wr(8'd9, 8'h70);
        wr(8'd9, 8'h60);
        rd_chk("ch2 underflow tcnt", 8'd11, ARL_WRAP);
        rd_chk("ch2 udf", 8'd10, 8'h02);
        rd_chk("ch2 tcr arl", 8'd9, TCR2_EXP);
        check("irq ch2 ie=0", IRQ, 4'b0000);

        // Ch0 CKS=11 and ch3 CKS=01, each enabled for exactly 64 edges
        wr(8'd0, 8'h10);
        wr(8'd1, 8'h80);
        wr(8'd1, 8'h00);
        wr(8'd12, 8'h10);
        wr(8'd13, 8'h80);
        wr(8'd13, 8'h00);
        wr(8'd1, 8'h13);
        wr(8'd13, 8'h11);
        repeat (60) @(negedge PCLK);
        wr(8'd1, 8'h03);
        wr(8'd13, 8'h01);
        rd_chk("ch0 cks11 64clk", 8'd3, 8'h14);
        rd_chk("ch3 cks01 64clk", 8'd15, 8'h20);
        rd_chk("ch1 unchanged", 8'd7, 8'h00);
        rd_chk("ch2 unchanged", 8'd11, ARL_WRAP);

        // Reset mid-count with a write in its access phase
        wr(8'd13, 8'h10);
        repeat (10) @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd12; PWDATA = 8'h77;
        @(negedge PCLK);
        PENABLE = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
        rd_chk("reset tcnt3", 8'd15, 8'h00);
        rd_chk("reset tcr3", 8'd13, 8'h00);
        rd_chk("reset discards write", 8'd12, 8'h00);
        rd_chk("reset tcnt0", 8'd3, 8'h00);
        rd_chk("reset tsr2", 8'd10, 8'h00);
        check("reset irq mid", IRQ, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
